// File: rtl/status_event_capture.sv
`default_nettype none
// status_event_capture: synchronizes pad events and reports live levels, sticky edge flags and saturating counters.
// Overflow flags in status register 0 are built only when EVENT_OVERFLOW_EN is defined.
module status_event_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_EVENTS  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_STATUS_REG = 2 + NUM_EVENTS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_EVENTS-1:0]                event_i,
  input  logic [NUM_EVENTS-1:0]                enable_i,
  input  logic [NUM_EVENTS-1:0]                edge_sel_i,
  input  logic                                 clear_i,
  output logic [NUM_EVENTS-1:0]                event_pulse_o,
  output logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_o
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = ($clog2(ARM_MAX + 1) > 3) ? $clog2(ARM_MAX + 1) : 3;
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_EVENTS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_EVENTS-1:0] sync;
  logic [NUM_EVENTS-1:0] prev;
  logic [NUM_EVENTS-1:0] flag;
  logic [NUM_EVENTS-1:0] overflow;
  logic [NUM_EVENTS-1:0] rise;
  logic [NUM_EVENTS-1:0] fall;
  logic [NUM_EVENTS-1:0] qual;
  logic [DATA_WIDTH-1:0] count_q [NUM_EVENTS];
  logic [ARM_W-1:0]      arm_cnt;
  logic                  armed;
  logic                  clear_q;
  logic                  clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= event_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync  = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_W'(ARM_MAX));
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
  // The arm window hides the edge an input already high at reset release would otherwise produce.
  assign qual  = ((edge_sel_i & fall) | (~edge_sel_i & rise)) & enable_i & {NUM_EVENTS{armed}};
  assign clr   = clear_i & ~clear_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev          <= '0;
      flag          <= '0;
      event_pulse_o <= '0;
      clear_q       <= 1'b0;
      arm_cnt       <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) count_q[i] <= '0;
    end else begin
      prev          <= sync;
      clear_q       <= clear_i;
      event_pulse_o <= qual;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clr) begin
          // An edge coinciding with clear is kept so no event is lost.
          flag[i]    <= qual[i];
          count_q[i] <= qual[i] ? DATA_WIDTH'(1) : '0;
        end else if (qual[i]) begin
          flag[i] <= 1'b1;
          if (count_q[i] != CNT_MAX) count_q[i] <= count_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef EVENT_OVERFLOW_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clr) overflow[i] <= 1'b0;
        else if (qual[i] && (count_q[i] == CNT_MAX)) overflow[i] <= 1'b1;
      end
    end
  end
`else
  assign overflow = '0;
`endif

  always_comb begin
    status_bus_o = '0;
    status_bus_o[NUM_EVENTS-1:0]            = sync;
    status_bus_o[2*NUM_EVENTS-1:NUM_EVENTS] = overflow;
    status_bus_o[DATA_WIDTH +: NUM_EVENTS]  = flag;
    for (int i = 0; i < NUM_EVENTS; i++)
      status_bus_o[(2+i)*DATA_WIDTH +: DATA_WIDTH] = count_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_status_event_capture.sv
`default_nettype none
// Bench for status_event_capture: vector table, hand sequences and a random run against a history-based model.
module tb_status_event_capture;

  localparam int DW   = 8;
  localparam int NE   = 4;
  localparam int SS   = 2;
  localparam int NREG = 2 + NE;
  localparam int BW   = DW * NREG;
`ifdef EVENT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [NE-1:0] ev;
  logic [NE-1:0] en;
  logic [NE-1:0] esel;
  logic [NE-1:0] pulse;
  logic [BW-1:0] bus;

  always #5 clk = ~clk;

  status_event_capture #(.DATA_WIDTH(DW), .NUM_EVENTS(NE), .SYNC_STAGES(SS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .event_i      (ev),
    .enable_i     (en),
    .edge_sel_i   (esel),
    .clear_i      (clear),
    .event_pulse_o(pulse),
    .status_bus_o (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: keeps the raw per-cycle input samples and derives levels by looking back in time.
  logic [NE-1:0] samp[$];
  int            k;
  logic          m_clear_prev;
  logic [NE-1:0] m_flag;
  logic [NE-1:0] m_ovf;
  logic [NE-1:0] m_pulse;
  int            m_cnt[NE];

  function automatic logic [NE-1:0] level_at(int n);
    if (n - SS >= 0) return samp[n-SS];
    return '0;
  endfunction

  task automatic model_step();
    logic [NE-1:0] cur, prv, edges, qual;
    logic          clr;
    bit            armed;
    if (rst) begin
      samp.delete();
      k = 0;
      m_clear_prev = 1'b0;
      m_flag = '0;
      m_ovf = '0;
      m_pulse = '0;
      for (int i = 0; i < NE; i++) m_cnt[i] = 0;
      return;
    end
    k++;
    samp.push_back(ev);
    cur   = level_at(k - 1);
    prv   = level_at(k - 2);
    armed = (k - 1) >= (SS + 1);
    for (int i = 0; i < NE; i++)
      edges[i] = esel[i] ? (!cur[i] && prv[i]) : (cur[i] && !prv[i]);
    qual = armed ? (edges & en) : '0;
    clr  = clear && !m_clear_prev;
    m_clear_prev = clear;
    for (int i = 0; i < NE; i++) begin
      if (clr) begin
        m_flag[i] = qual[i];
        m_cnt[i]  = qual[i] ? 1 : 0;
        m_ovf[i]  = 1'b0;
      end else if (qual[i]) begin
        m_flag[i] = 1'b1;
        if (m_cnt[i] == (1 << DW) - 1) m_ovf[i] = OVF_EN;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_pulse = qual;
  endtask

  function automatic logic [BW-1:0] exp_bus();
    logic [BW-1:0] b;
    b = '0;
    b[NE-1:0]    = level_at(k);
    b[2*NE-1:NE] = m_ovf;
    b[DW +: NE]  = m_flag;
    for (int i = 0; i < NE; i++) b[(2+i)*DW +: DW] = DW'(m_cnt[i]);
    return b;
  endfunction

  function automatic logic [DW-1:0] reg_of(int r);
    return bus[r*DW +: DW];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_bus", bus, exp_bus());
    check("model_pulse", pulse, m_pulse);
  endtask

  typedef struct {
    logic [NE-1:0] ev;
    logic [NE-1:0] lvl;
    logic [NE-1:0] pls;
  } vec_t;
  vec_t tbl[13];

  logic [NE-1:0] seen;

  initial begin
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0010, 4'b0010, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b0010, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0100, 4'b0100, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0100, 4'b0100};
    tbl[9]  = '{4'b1000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0000, 4'b1000, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b1000};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000};

    // Reset with all inputs high, then release: no spurious edges.
    rst = 1'b1; ev = '1; en = '1; esel = '0; clear = 1'b0;
    repeat (3) tick();
    check("reset_bus", bus, 64'd0);
    check("reset_pulse", pulse, 64'd0);
    rst = 1'b0;
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen |= pulse;
    end
    check("arm_reg0", reg_of(0), 8'h0F);
    check("arm_reg1", reg_of(1), 8'h00);
    for (int i = 0; i < NE; i++) check("arm_count", reg_of(2 + i), 8'h00);
    check("arm_no_pulse", seen, 64'd0);

    // Three rising pulses on event 2.
    ev = '0;
    repeat (4) tick();
    for (int p = 0; p < 3; p++) begin
      ev[2] = 1'b1; repeat (4) tick();
      ev[2] = 1'b0; repeat (4) tick();
    end
    check("rise_reg1", reg_of(1), 8'h04);
    check("rise_reg4", reg_of(4), 8'h03);

    // Clear on rising clear_i, then holding it high does not re-clear.
    clear = 1'b1;
    tick();
    for (int r = 1; r < NREG; r++) check("clear_reg", reg_of(r), 8'h00);
    ev[2] = 1'b1; repeat (4) tick();
    ev[2] = 1'b0; repeat (2) tick();
    check("hold_clear_reg4", reg_of(4), 8'h01);
    check("hold_clear_reg1", reg_of(1), 8'h04);
    clear = 1'b0;
    tick();

    // Table: falling select on event 0, event 1 disabled.
    clear = 1'b1; tick();
    clear = 1'b0;
    esel = 4'b0001; en = 4'b1101; ev = '0;
    repeat (3) tick();
    for (int r = 0; r < 13; r++) begin
      ev = tbl[r].ev;
      tick();
      check("tbl_level", bus[NE-1:0], tbl[r].lvl);
      check("tbl_pulse", pulse, tbl[r].pls);
    end
    check("tbl_reg2", reg_of(2), 8'h01);
    check("tbl_reg3", reg_of(3), 8'h00);
    check("tbl_reg4", reg_of(4), 8'h01);
    check("tbl_reg5", reg_of(5), 8'h01);

    // Saturation on event 3.
    en = '1; esel = '0;
    for (int p = 0; p < 260; p++) begin
      ev[3] = 1'b1; repeat (2) tick();
      ev[3] = 1'b0; repeat (2) tick();
    end
    repeat (3) tick();
    check("sat_reg5", reg_of(5), 8'hFF);
    check("sat_ovf_bit7", bus[7], OVF_EN);
    check("sat_flag3", bus[DW+3], 1'b1);

    // Clear edge coincides with a qualified edge on event 0.
    ev[0] = 1'b1; tick(); tick();
    clear = 1'b1; tick();
    check("coinc_reg1", reg_of(1), 8'h01);
    check("coinc_reg2", reg_of(2), 8'h01);
    check("coinc_reg3", reg_of(3), 8'h00);
    check("coinc_reg4", reg_of(4), 8'h00);
    check("coinc_reg5", reg_of(5), 8'h00);
    check("coinc_ovf", bus[2*NE-1:NE], 64'd0);
    clear = 1'b0; ev = '0;
    tick();

    // Random run against the model.
    for (int c = 0; c < 1500; c++) begin
      ev = NE'($urandom);
      if ($urandom_range(0, 15) == 0) en = NE'($urandom);
      if ($urandom_range(0, 15) == 0) esel = NE'($urandom);
      if ($urandom_range(0, 7) == 0) clear = ~clear;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
